alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response channels between a requester and the ALU sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_rs1_val;
  logic [31:0] req_rs2_val;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_funct7, req_rs1_val, req_rs2_val, req_rd,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_rd, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_funct7, req_rs1_val, req_rs2_val, req_rd,
    output req_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_rd, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one R-type operation at a time through an external combinational ALU,
// holding operands for MUL_LATENCY cycles on multiplies and returning a captured response.
module alu_sequencer #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_MUL = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;

  localparam logic [3:0] CNT_INIT  = 4'(MUL_LATENCY - 1);
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [3:0]  dec_ctrl;
  logic        dec_legal;
  logic        accept;
  logic        capture;
  logic        load_cnt;

  always_comb begin
    dec_ctrl  = CTRL_AND;
    dec_legal = 1'b1;
    case ({bus.req_funct7, bus.req_funct3})
      10'b0000000_000: dec_ctrl = CTRL_ADD;
      10'b0100000_000: dec_ctrl = CTRL_SUB;
      10'b0000000_111: dec_ctrl = CTRL_AND;
      10'b0000000_110: dec_ctrl = CTRL_OR;
      10'b0000000_010: dec_ctrl = CTRL_SLT;
      10'b0000001_000: dec_ctrl = CTRL_MUL;
      default:         dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    load_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = dec_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        // A single-cycle multiply is indistinguishable from any other operation.
        if (alu_ctrl == CTRL_MUL && MUL_MULTI) begin
          load_cnt   = 1'b1;
          state_next = WAIT_MUL;
        end else begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_MUL: begin
        if (cnt == 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= 4'd0;
      alu_a           <= 32'd0;
      alu_b           <= 32'd0;
      alu_ctrl        <= 4'd0;
      bus.rsp_result  <= 32'd0;
      bus.rsp_zero    <= 1'b0;
      bus.rsp_rd      <= 5'd0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        bus.rsp_rd <= bus.req_rd;
        if (dec_legal) begin
          alu_a    <= bus.req_rs1_val;
          alu_b    <= bus.req_rs2_val;
          alu_ctrl <= dec_ctrl;
        end else begin
          // Unsupported encodings skip the ALU and leave its operands untouched.
          bus.rsp_result  <= 32'd0;
          bus.rsp_zero    <= 1'b1;
          bus.rsp_illegal <= 1'b1;
        end
      end
      if (load_cnt)               cnt <= CNT_INIT;
      else if (state == WAIT_MUL) cnt <= cnt - 4'd1;
      if (capture) begin
        bus.rsp_result  <= alu_result;
        bus.rsp_zero    <= alu_zero;
        bus.rsp_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU on the ALU port, directed and random
// operations scored through an expected-response queue, backpressure and reset abort.
module tb_alu_sequencer;
  localparam int L = 3;
  localparam int W = 39;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, busy;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0]  last_ctrl;
  logic [31:0] last_a, last_b;

  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.MUL_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // returns {legal, ctrl}
  function automatic logic [4:0] dec_ref(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      10'b0000000_000: return 5'b1_0010;
      10'b0100000_000: return 5'b1_0110;
      10'b0000000_111: return 5'b1_0000;
      10'b0000000_110: return 5'b1_0001;
      10'b0000000_010: return 5'b1_0111;
      10'b0000001_000: return 5'b1_1000;
      default:         return 5'b0_0000;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return {31'd0, ($signed(a) < $signed(b))};
      4'b1000: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rsp_now();
    return {bus.rsp_illegal, bus.rsp_zero, bus.rsp_rd, bus.rsp_result};
  endfunction

  task automatic garble_req();
    bus.req_funct7  = 7'($urandom_range(0, 127));
    bus.req_funct3  = 3'($urandom_range(0, 7));
    bus.req_rs1_val = $urandom;
    bus.req_rs2_val = $urandom;
    bus.req_rd      = 5'($urandom_range(0, 31));
  endtask

  // Latency counts rising edges starting with the accepting edge as 1.
  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int hold);
    logic [4:0]   d;
    logic [31:0]  r;
    logic [W-1:0] exp;
    int lat, exp_lat;
    d = dec_ref(f7, f3);
    r = alu_model(d[3:0], a, b);
    if (d[4]) exp = {1'b0, (r == 32'd0), rd, r};
    else      exp = {1'b1, 1'b1, rd, 32'd0};
    if (!d[4])                    exp_lat = 1;
    else if (d[3:0] == 4'b1000)   exp_lat = (L > 1) ? 1 + L : 2;
    else                          exp_lat = 2;
    exp_q.push_back(exp);

    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_funct7 = f7; bus.req_funct3 = f3;
    bus.req_rs1_val = a; bus.req_rs2_val = b; bus.req_rd = rd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    garble_req();
    if (d[4]) begin
      last_ctrl = d[3:0]; last_a = a; last_b = b;
    end
    check("alu_ctrl", alu_ctrl, last_ctrl);
    check("alu_a", alu_a, last_a);
    check("alu_b", alu_b, last_b);

    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      check("alu_ctrl_stable", alu_ctrl, last_ctrl);
      check("alu_ab_stable", {alu_a, alu_b}, {last_a, last_b});
      bus.req_valid = 1'($urandom_range(0, 1));
      garble_req();
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    exp = exp_q.pop_front();
    check("rsp_fields", rsp_now(), exp);

    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      garble_req();
      @(negedge clk);
      check("rsp_hold_fields", rsp_now(), exp);
      check("rsp_hold_valid", bus.rsp_valid, 1);
      check("req_ready_busy", bus.req_ready, 0);
      check("alu_ctrl_hold", alu_ctrl, last_ctrl);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("back_to_idle", {dbg_state, busy, bus.rsp_valid, bus.req_ready}, {2'd0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctl"}, {bus.req_ready, busy, bus.rsp_valid, dbg_state}, {1'b1, 1'b0, 1'b0, 2'd0});
    check({tag, "_alu"}, {alu_a, alu_b, alu_ctrl}, 68'd0);
    check({tag, "_rsp"}, rsp_now(), {W{1'b0}});
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_funct7 = '0; bus.req_funct3 = '0;
    bus.req_rs1_val = '0; bus.req_rs2_val = '0; bus.req_rd = '0;
    last_ctrl = '0; last_a = '0; last_b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_op(7'b0000000, 3'b000, 32'd5, 32'd7, 5'd3, 0);
    run_op(7'b0100000, 3'b000, 32'h10, 32'h10, 5'd9, 0);
    run_op(7'b0000001, 3'b000, 32'd6, 32'd7, 5'd12, 0);
    run_op(7'b0000000, 3'b001, 32'd1, 32'd2, 5'd17, 0);
    run_op(7'b0000000, 3'b111, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4, 5);
    run_op(7'b0000000, 3'b110, 32'hA000_0000, 32'h0000_0005, 5'd31, 1);
    run_op(7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd1, 2);
    run_op(7'b0000000, 3'b010, 32'd1, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(7'b1111111, 3'b000, 32'd3, 32'd3, 5'd0, 3);

    for (int n = 0; n < 30; n++) begin
      logic [6:0] f7;
      logic [2:0] f3;
      logic [9:0] enc;
      case ($urandom_range(0, 6))
        0: enc = 10'b0000000_000;
        1: enc = 10'b0100000_000;
        2: enc = 10'b0000000_111;
        3: enc = 10'b0000000_110;
        4: enc = 10'b0000000_010;
        5: enc = 10'b0000001_000;
        default: enc = 10'($urandom_range(0, 1023));
      endcase
      f7 = enc[9:3];
      f3 = enc[2:0];
      run_op(f7, f3, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    // Abort a multiply while it waits and confirm no response ever appears.
    @(negedge clk);
    bus.req_funct7 = 7'b0000001; bus.req_funct3 = 3'b000;
    bus.req_rs1_val = 32'd11; bus.req_rs2_val = 32'd13; bus.req_rd = 5'd21;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mul_exec_state", dbg_state, 2'd1);
    @(negedge clk);
    check("mul_wait_state", dbg_state, 2'd2);
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
